ru_fault_scheduler: RTL and testbench
=====================================

// Module: ru_fault_scheduler
// PURPOSE
//  Allocates the faulty PEs reported by the STW self-test map onto a limited pool of recompute units (RUs).
//  Scans the map in row-major order and packs up to NUM_RU faulty PEs into one "pass".
//  Hands each pass to the OS recompute controller over a valid/ready handshake, then waits for pass_done.
//  Repeats until every faulty PE is covered, so fault counts above NUM_RU are serviced in several passes.
// PARAMETERS
//  ROWS    4  systolic array rows
//  COLS    4  systolic array columns
//  NUM_RU  4  recompute units available per pass (1..ROWS*COLS)
// PORTS
//  clk             in   1                  single clock, rising edge
//  rst_n           in   1                  asynchronous, active-low reset
//  stw_valid       in   1                  pulse: new fault map on stw_result_mat
//  stw_result_mat  in   ROWS*COLS          bit r*COLS+c: 1=PE good, 0=PE faulty
//  pass_valid      out  1                  current pass mapping is valid
//  pass_ready      in   1                  consumer accepts the pass
//  pass_done       in   1                  pulse: consumer finished recompute of the accepted pass
//  ru_en           out  NUM_RU             slot k holds a faulty PE
//  ru_row_mapping  out  NUM_RU*$clog2(ROWS) slot k row at [k*RW +: RW]
//  ru_col_mapping  out  NUM_RU*$clog2(COLS) slot k col at [k*CW +: CW]
//  busy            out  1                  state != IDLE
//  sched_done      out  1                  1-cycle pulse: all faults serviced
//  fault_count     out  $clog2(ROWS*COLS+1) faulty PEs in latched map (stats)
//  pass_count      out  $clog2(ROWS*COLS+1) passes accepted (stats)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; slots cleared; scan index 0; latched map all-ones.
//  States: IDLE, SCAN, ISSUE, WAIT, DONE.
//  IDLE: stw_valid -> latch map, index=0, clear slots and counters, go to SCAN.
//  SCAN: examine one bit per cycle at index i.
//   - Bit=0: write (i/COLS, i%COLS) into the next free slot and set its ru_en bit.
//   - Slots full, or i==ROWS*COLS-1 with >=1 slot used -> ISSUE.
//   - i==ROWS*COLS-1 with 0 slots used -> DONE.
//   - Otherwise i++.
//  ISSUE: pass_valid=1; mapping and ru_en held stable.
//   - pass_ready=1 -> pass_count++, go to WAIT. Handshake completes in the same cycle as pass_valid&&pass_ready.
//  WAIT: pass_valid=0; mapping and ru_en still held.
//   - pass_done -> clear slots; if scan had ended go to DONE, else i++ and go to SCAN.
//  DONE: sched_done=1 for one cycle, slots cleared, go to IDLE.
//  Latency: stw_valid in cycle 0; SCAN covers cycles 1..ROWS*COLS; ISSUE no earlier than cycle 2.
//  Boundaries:
//   - stw_valid while not IDLE: abort. Relatch the map, clear slots and counters, restart SCAN next cycle, drop pass_valid.
//   - stw_valid has priority over pass_done and pass_ready in the same cycle.
//   - pass_done outside WAIT is ignored; pass_ready outside ISSUE is ignored.
//   - Last PE faulty and fills the last slot: one ISSUE only, then DONE after WAIT.
//   - All-ones map: no pass issued; sched_done at cycle ROWS*COLS+1.
//  fault_count increments once per faulty bit scanned; it never exceeds ROWS*COLS.
// CONFIGURATION
//  BISR_FAULT_STATS_EN defined: fault_count and pass_count are live as specified.
//  Not defined: both ports are tied to 0 and their counters are not synthesised. All other behaviour is identical.
// STRUCTURE
//  bisr_pkg holds:
//   - sched_state_t enum {IDLE, SCAN, ISSUE, WAIT, DONE};
//   - RW/CW/IDXW width helpers.
//  Sub-module ru_slot_table (NUM_RU entries): clear, write-next, full flag, used count, packed mapping and ru_en outputs.
//  Top level: FSM, scan index counter, map latch, stats counters.
// TESTING
//  1. Reset mid-SCAN via rst_n low -> all outputs 0 immediately (async); state IDLE; busy=0.
//  2. NUM_RU=4, map 16'hFFBD -> one ISSUE at cycle 17:
//     - ru_en=4'b0011; slot0=(r0,c1), slot1=(r1,c2);
//     - pass_ready, then pass_done -> sched_done; fault_count=2, pass_count=1.
//  3. NUM_RU=2, map 16'hF7BD, two passes:
//     - pass1 slots (0,1),(1,2), issued after index 6;
//     - pass2 ru_en=2'b01, slot0=(2,3);
//     - sched_done after second pass_done; pass_count=2.
//  4. Map 16'hFFFF -> no pass_valid; sched_done at cycle 17; fault_count=0.
//  5. In WAIT of test 2, pulse stw_valid with 16'hFBFF:
//     - abort and rescan; single pass with slot0=(r2,c2), ru_en=4'b0001;
//     - an earlier stale pass_done is ignored.
//  6. Hold pass_ready=0 for 10 cycles in ISSUE -> pass_valid and mapping stay stable; no counter change.

Source files
------------

// File: rtl/bisr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bisr_pkg
// Brief    : Shared types and width helpers for the BISR fault scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package bisr_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    // Index width that stays at least one bit wide for degenerate sizes
    function automatic int clog2_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rw_of(input int rows);
        return clog2_w(rows);
    endfunction

    function automatic int cw_of(input int cols);
        return clog2_w(cols);
    endfunction

    function automatic int idxw_of(input int rows, input int cols);
        return clog2_w(rows * cols);
    endfunction

endpackage : bisr_pkg
`default_nettype wire

// File: rtl/ru_slot_table.sv
`default_nettype none
// ============================================================================
// Module   : ru_slot_table
// Brief    : NUM_RU-entry table of (row, col) recompute slots filled in order.
// Revision : 1.0 - initial release
// ============================================================================
module ru_slot_table #(
    parameter int  NUM_RU = 4,
    parameter int  RW     = 2,
    parameter int  CW     = 2,
    localparam int UW     = $clog2(NUM_RU + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [RW-1:0]        wr_row,
    input  logic [CW-1:0]        wr_col,
    output logic                 full,
    output logic [UW-1:0]        used,
    output logic [NUM_RU-1:0]    ru_en,
    output logic [NUM_RU*RW-1:0] row_map,
    output logic [NUM_RU*CW-1:0] col_map
);

    logic [UW-1:0] r_used;
    logic          w_wr_ok;

    assign full    = (r_used == UW'(NUM_RU));
    assign used    = r_used;
    assign w_wr_ok = wr_en && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_used <= '0;
        end else if (clear) begin
            r_used <= '0;
        end else if (w_wr_ok) begin
            r_used <= r_used + 1'b1;
        end
    end

    // The next free slot is always the one indexed by the current fill count
    for (genvar k = 0; k < NUM_RU; k++) begin : g_slot
        logic          r_en;
        logic [RW-1:0] r_row;
        logic [CW-1:0] r_col;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_en  <= 1'b0;
                r_row <= '0;
                r_col <= '0;
            end else if (clear) begin
                r_en  <= 1'b0;
                r_row <= '0;
                r_col <= '0;
            end else if (w_wr_ok && (r_used == UW'(k))) begin
                r_en  <= 1'b1;
                r_row <= wr_row;
                r_col <= wr_col;
            end
        end

        assign ru_en[k]              = r_en;
        assign row_map[k*RW +: RW]   = r_row;
        assign col_map[k*CW +: CW]   = r_col;
    end

endmodule : ru_slot_table
`default_nettype wire

// File: rtl/ru_fault_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ru_fault_scheduler
// Brief    : Packs faulty PEs from the self-test map into recompute-unit passes
//            and hands them out over valid/ready, one pass at a time.
//            Optional macro BISR_FAULT_STATS_EN enables fault/pass counters.
// Revision : 1.0 - initial release
// ============================================================================
module ru_fault_scheduler
    import bisr_pkg::*;
#(
    parameter int  ROWS   = 4,
    parameter int  COLS   = 4,
    parameter int  NUM_RU = 4,
    localparam int RW     = rw_of(ROWS),
    localparam int CW     = cw_of(COLS),
    localparam int IDXW   = idxw_of(ROWS, COLS),
    localparam int CNTW   = $clog2(ROWS * COLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stw_valid,
    input  logic [ROWS*COLS-1:0] stw_result_mat,
    output logic                 pass_valid,
    input  logic                 pass_ready,
    input  logic                 pass_done,
    output logic [NUM_RU-1:0]    ru_en,
    output logic [NUM_RU*RW-1:0] ru_row_mapping,
    output logic [NUM_RU*CW-1:0] ru_col_mapping,
    output logic                 busy,
    output logic                 sched_done,
    output logic [CNTW-1:0]      fault_count,
    output logic [CNTW-1:0]      pass_count
);

    localparam int UW = $clog2(NUM_RU + 1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [ROWS*COLS-1:0]  r_map;
    logic [IDXW-1:0]       r_idx;
    logic                  r_scan_end;

    logic                  w_latch;
    logic                  w_slot_clr;
    logic                  w_slot_wr;
    logic                  w_idx_inc;
    logic                  w_end_set;
    logic                  w_fault;
    logic                  w_last;
    logic                  w_fills;
    logic                  w_slot_full;
    logic [UW-1:0]         w_used;
    logic [RW-1:0]         w_row;
    logic [CW-1:0]         w_col;

    assign w_fault = (r_state == SCAN) && !r_map[r_idx];
    assign w_last  = (r_idx == IDXW'(ROWS * COLS - 1));
    assign w_fills = w_fault && (w_used == UW'(NUM_RU - 1));
    assign w_row   = RW'(int'(r_idx) / COLS);
    assign w_col   = CW'(int'(r_idx) % COLS);

    ru_slot_table #(
        .NUM_RU (NUM_RU),
        .RW     (RW),
        .CW     (CW)
    ) u_slots (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_slot_clr),
        .wr_en   (w_slot_wr),
        .wr_row  (w_row),
        .wr_col  (w_col),
        .full    (w_slot_full),
        .used    (w_used),
        .ru_en   (ru_en),
        .row_map (ru_row_mapping),
        .col_map (ru_col_mapping)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_slot_clr  = 1'b0;
        w_slot_wr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_end_set   = 1'b0;
        // A new map restarts the scheduler from any state, ahead of handshakes
        if (stw_valid) begin
            w_latch     = 1'b1;
            w_slot_clr  = 1'b1;
            w_state_nxt = SCAN;
        end else begin
            case (r_state)
                IDLE: ;
                SCAN: begin
                    w_slot_wr = w_fault && !w_slot_full;
                    if (w_slot_full || w_fills) begin
                        // A full table holds the index so an unwritten bit is retried
                        w_end_set   = w_last && !w_slot_full;
                        w_state_nxt = ISSUE;
                    end else if (w_last) begin
                        w_end_set   = 1'b1;
                        w_state_nxt = ((w_used != '0) || w_fault) ? ISSUE : DONE;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
                ISSUE: begin
                    if (pass_ready) begin
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (pass_done) begin
                        w_slot_clr = 1'b1;
                        if (r_scan_end) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_idx_inc   = 1'b1;
                            w_state_nxt = SCAN;
                        end
                    end
                end
                DONE: begin
                    w_slot_clr  = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_map      <= '1;
            r_idx      <= '0;
            r_scan_end <= 1'b0;
        end else if (w_latch) begin
            r_map      <= stw_result_mat;
            r_idx      <= '0;
            r_scan_end <= 1'b0;
        end else begin
            if (w_idx_inc) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_end_set) begin
                r_scan_end <= 1'b1;
            end
        end
    end

    assign pass_valid = (r_state == ISSUE);
    assign busy       = (r_state != IDLE);
    assign sched_done = (r_state == DONE);

`ifdef BISR_FAULT_STATS_EN
    logic [CNTW-1:0] r_fault_cnt;
    logic [CNTW-1:0] r_pass_cnt;
    logic            w_pass_acc;

    assign w_pass_acc = (r_state == ISSUE) && pass_ready && !stw_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_cnt <= '0;
            r_pass_cnt  <= '0;
        end else if (w_latch) begin
            r_fault_cnt <= '0;
            r_pass_cnt  <= '0;
        end else begin
            if (w_slot_wr) begin
                r_fault_cnt <= r_fault_cnt + 1'b1;
            end
            if (w_pass_acc) begin
                r_pass_cnt <= r_pass_cnt + 1'b1;
            end
        end
    end

    assign fault_count = r_fault_cnt;
    assign pass_count  = r_pass_cnt;
`else
    assign fault_count = '0;
    assign pass_count  = '0;
`endif

endmodule : ru_fault_scheduler
`default_nettype wire

// File: tb/tb_ru_fault_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ru_fault_scheduler
// Brief    : Directed, table-driven bench for ru_fault_scheduler (NUM_RU=4 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ru_fault_scheduler;

    logic clk;
    logic rst_n;

    // NUM_RU = 4 instance
    logic        a_stw_valid;
    logic [15:0] a_map;
    logic        a_pass_valid, a_pass_ready, a_pass_done;
    logic [3:0]  a_ru_en;
    logic [7:0]  a_rows, a_cols;
    logic        a_busy, a_sched_done;
    logic [4:0]  a_fault_count, a_pass_count;

    // NUM_RU = 2 instance
    logic        b_stw_valid;
    logic [15:0] b_map;
    logic        b_pass_valid, b_pass_ready, b_pass_done;
    logic [1:0]  b_ru_en;
    logic [3:0]  b_rows, b_cols;
    logic        b_busy, b_sched_done;
    logic [4:0]  b_fault_count, b_pass_count;

    int checks = 0;
    int errors = 0;

    ru_fault_scheduler #(.ROWS(4), .COLS(4), .NUM_RU(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stw_valid(a_stw_valid), .stw_result_mat(a_map),
        .pass_valid(a_pass_valid), .pass_ready(a_pass_ready), .pass_done(a_pass_done),
        .ru_en(a_ru_en), .ru_row_mapping(a_rows), .ru_col_mapping(a_cols),
        .busy(a_busy), .sched_done(a_sched_done),
        .fault_count(a_fault_count), .pass_count(a_pass_count)
    );

    ru_fault_scheduler #(.ROWS(4), .COLS(4), .NUM_RU(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stw_valid(b_stw_valid), .stw_result_mat(b_map),
        .pass_valid(b_pass_valid), .pass_ready(b_pass_ready), .pass_done(b_pass_done),
        .ru_en(b_ru_en), .ru_row_mapping(b_rows), .ru_col_mapping(b_cols),
        .busy(b_busy), .sched_done(b_sched_done),
        .fault_count(b_fault_count), .pass_count(b_pass_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] map;
        logic [3:0]  en;     // 0 means no pass is expected
        logic [7:0]  rows;
        logic [7:0]  cols;
        int          cyc;    // cycle of first pass_valid, or of sched_done
        int          faults;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [4:0] es(input int v);
`ifdef BISR_FAULT_STATS_EN
        return 5'(v);
`else
        return (v == v) ? 5'd0 : 5'd1;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic start4(input logic [15:0] m);
        @(negedge clk);
        a_stw_valid = 1'b1;
        a_map       = m;
        @(negedge clk);
        a_stw_valid = 1'b0;
    endtask

    // Returns the cycle (relative to stw_valid at cycle 0) of pass_valid or sched_done
    task automatic wait4(input int n0, output int n);
        n = n0;
        while (!(a_pass_valid || a_sched_done) && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Accept the pending pass, finish it, and expect no further pass before sched_done
    task automatic finish4(input string tag, input int faults, input int passes);
        int  k;
        logic extra;
        a_pass_ready = 1'b1;
        @(negedge clk);
        a_pass_ready = 1'b0;
        chk({tag, "_wait_novalid"}, 32'(a_pass_valid), 32'd0);
        a_pass_done = 1'b1;
        @(negedge clk);
        a_pass_done = 1'b0;
        k     = 0;
        extra = 1'b0;
        while (!a_sched_done && k < 40) begin
            if (a_pass_valid) extra = 1'b1;
            @(negedge clk);
            k++;
        end
        chk({tag, "_sched_done"}, 32'(a_sched_done), 32'd1);
        chk({tag, "_no_extra_pass"}, 32'(extra), 32'd0);
        chk({tag, "_fault_count"}, 32'(a_fault_count), 32'(es(faults)));
        chk({tag, "_pass_count"}, 32'(a_pass_count), 32'(es(passes)));
        @(negedge clk);
        chk({tag, "_idle"}, 32'(a_busy), 32'd0);
    endtask

    task automatic run_vec(input int i);
        int n;
        string t;
        t = $sformatf("vec%0d", i);
        start4(tbl[i].map);
        wait4(1, n);
        chk({t, "_cycle"}, 32'(n), 32'(tbl[i].cyc));
        if (tbl[i].en == 4'd0) begin
            chk({t, "_nopass"}, 32'(a_pass_valid), 32'd0);
            chk({t, "_done"}, 32'(a_sched_done), 32'd1);
            chk({t, "_fault_count"}, 32'(a_fault_count), 32'(es(0)));
            @(negedge clk);
        end else begin
            chk({t, "_ru_en"}, 32'(a_ru_en), 32'(tbl[i].en));
            chk({t, "_rows"}, 32'(a_rows), 32'(tbl[i].rows));
            chk({t, "_cols"}, 32'(a_cols), 32'(tbl[i].cols));
            finish4(t, tbl[i].faults, 1);
        end
    endtask

    initial begin
        int   n;
        logic stable;

        tbl[0] = '{16'hFFBD, 4'b0011, 8'h04, 8'h09, 17, 2};
        tbl[1] = '{16'h7FFF, 4'b0001, 8'h03, 8'h03, 17, 1};
        tbl[2] = '{16'hFFFE, 4'b0001, 8'h00, 8'h00, 17, 1};
        tbl[3] = '{16'hFFF0, 4'b1111, 8'h00, 8'hE4, 5, 4};
        tbl[4] = '{16'h6FFF, 4'b0011, 8'h0F, 8'h0C, 17, 2};
        tbl[5] = '{16'h7FF8, 4'b1111, 8'hC0, 8'hE4, 17, 4};
        tbl[6] = '{16'hFFFF, 4'b0000, 8'h00, 8'h00, 17, 0};

        rst_n        = 1'b0;
        a_stw_valid  = 1'b0; a_map = 16'hFFFF; a_pass_ready = 1'b0; a_pass_done = 1'b0;
        b_stw_valid  = 1'b0; b_map = 16'hFFFF; b_pass_ready = 1'b0; b_pass_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset_outputs4", {a_pass_valid, a_busy, a_sched_done, a_ru_en, a_rows, a_cols,
                               a_fault_count, a_pass_count}, 32'd0);
        chk("reset_outputs2", {b_pass_valid, b_busy, b_sched_done, b_ru_en, b_rows, b_cols,
                               b_fault_count, b_pass_count}, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Async reset in the middle of a scan
        start4(16'hFFBD);
        repeat (4) @(negedge clk);
        chk("midscan_busy", 32'(a_busy), 32'd1);
        chk("midscan_ru_en", 32'(a_ru_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {a_pass_valid, a_busy, a_sched_done, a_ru_en, a_rows,
                                    a_cols, a_fault_count, a_pass_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_reset_idle", {a_busy, a_pass_valid, a_ru_en}, 32'd0);

        // Two passes with NUM_RU=2
        @(negedge clk);
        b_stw_valid = 1'b1;
        b_map       = 16'hF7BD;
        @(negedge clk);
        b_stw_valid = 1'b0;
        n = 1;
        while (!b_pass_valid && n < 60) begin @(negedge clk); n++; end
        chk("b_pass1_cycle", 32'(n), 32'd8);
        chk("b_pass1_ru_en", 32'(b_ru_en), 32'h3);
        chk("b_pass1_map", {b_rows, b_cols}, 32'h49);
        b_pass_ready = 1'b1;
        @(negedge clk);
        b_pass_ready = 1'b0;
        b_pass_done  = 1'b1;
        @(negedge clk);
        b_pass_done = 1'b0;
        n = 0;
        while (!b_pass_valid && n < 40) begin @(negedge clk); n++; end
        chk("b_pass2_valid", 32'(b_pass_valid), 32'd1);
        chk("b_pass2_ru_en", 32'(b_ru_en), 32'h1);
        chk("b_pass2_map", {b_rows, b_cols}, 32'h23);
        b_pass_ready = 1'b1;
        @(negedge clk);
        b_pass_ready = 1'b0;
        b_pass_done  = 1'b1;
        @(negedge clk);
        b_pass_done = 1'b0;
        chk("b_sched_done", 32'(b_sched_done), 32'd1);
        chk("b_stats", {b_fault_count, b_pass_count}, {22'd0, es(3), es(2)});

        // Abort from WAIT with a simultaneous pass_done, then a stale pass_done
        start4(16'hFFBD);
        wait4(1, n);
        chk("abort_first_issue", 32'(n), 32'd17);
        a_pass_ready = 1'b1;
        @(negedge clk);
        a_pass_ready = 1'b0;
        a_stw_valid  = 1'b1;
        a_map        = 16'hFBFF;
        a_pass_done  = 1'b1;
        @(negedge clk);
        a_stw_valid = 1'b0;
        a_pass_done = 1'b0;
        chk("abort_state", {a_pass_valid, a_busy, a_sched_done, a_ru_en}, 32'b0_1_0_0000);
        a_pass_done = 1'b1;
        @(negedge clk);
        a_pass_done = 1'b0;
        wait4(2, n);
        chk("abort_issue_cycle", 32'(n), 32'd17);
        chk("abort_ru_en", 32'(a_ru_en), 32'h1);
        chk("abort_map", {a_rows, a_cols}, 32'h0202);
        finish4("abort", 1, 1);

        // Consumer stalls for 10 cycles in ISSUE
        start4(16'hFFBD);
        wait4(1, n);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!(a_pass_valid && a_ru_en == 4'b0011 && a_rows == 8'h04 && a_cols == 8'h09
                  && a_pass_count == es(0))) stable = 1'b0;
            @(negedge clk);
        end
        chk("stall_stable", 32'(stable), 32'd1);
        chk("stall_still_valid", 32'(a_pass_valid), 32'd1);
        finish4("stall", 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ru_fault_scheduler
`default_nettype wire
